// File: rtl/game_pkg.sv
// Shared types and constants for the runner-game sequencer: state encoding,
// datapath widths and the obstacle-scheduling LFSR.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int SCORE_W = 14;
  localparam int SPEED_W = 4;
  localparam int GAP_W   = 6;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: feedback taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous board input, with a registered
// rising-edge pulse and its one-cycle-early precursor.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_level,
  output logic o_edge,
  output logic o_edge_nxt
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_edge;

  // Synchronizer chain, delayed level copy and edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_edge <= r_sync & ~r_prev;
    end
  end

  assign o_level    = r_sync;
  assign o_edge     = r_edge;
  // Value o_edge takes on the next clk; lets a consumer register a pulse aligned with o_edge
  assign o_edge_nxt = r_sync & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Run-time controller for the runner game: game FSM, step tick, score and
// high score, scroll speed, obstacle spawn scheduling and animation phase.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 1250000,
  parameter int SPEED_MIN  = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 100,
  parameter int GAP_MIN    = 24,
  parameter int ANIM_DIV   = 4,
  parameter int SCORE_MAX  = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_btn,
  input  logic               stop_sw,
  input  logic               collide,
  output logic [1:0]         state,
  output logic               run_en,
  output logic               game_tick,
  output logic               jump_req,
  output logic               spawn,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               anim_phase
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int ANIM_W = $clog2(ANIM_DIV + 1);
  localparam int STEP_W = $clog2(SPEED_STEP + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [ANIM_W-1:0]  ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [SPEED_W-1:0] SPD_MIN   = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] SC_MAX    = SCORE_W'(SCORE_MAX);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_MIN);

  logic w_jump_edge;
  logic w_jump_edge_nxt;
  logic w_jump_level_unused;
  logic w_stop_q;
  logic w_stop_edge_unused;
  logic w_stop_edge_nxt_unused;
  logic w_div_last;
  logic [7:0] w_lfsr_nxt;

  state_t              r_state;
  logic                r_run_en;
  logic [DIV_W-1:0]    r_div;
  logic                r_tick;
  logic                r_spawn;
  logic                r_jump_req;
  logic [SPEED_W-1:0]  r_speed;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  r_hi;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic [7:0]          r_lfsr;
  logic [ANIM_W-1:0]   r_anim_cnt;
  logic                r_anim;

  btn_sync_edge u_jump (
    .clk        (clk),
    .rst_n      (rst),
    .i_din      (jump_btn),
    .o_level    (w_jump_level_unused),
    .o_edge     (w_jump_edge),
    .o_edge_nxt (w_jump_edge_nxt)
  );

  btn_sync_edge u_stop (
    .clk        (clk),
    .rst_n      (rst),
    .i_din      (stop_sw),
    .o_level    (w_stop_q),
    .o_edge     (w_stop_edge_unused),
    .o_edge_nxt (w_stop_edge_nxt_unused)
  );

  assign w_div_last = (r_div == DIV_LAST);
  assign w_lfsr_nxt = lfsr_next(r_lfsr);

  // Game FSM with divider, score/speed, spawn scheduler and animation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_run_en   <= 1'b0;
      r_div      <= '0;
      r_tick     <= 1'b0;
      r_spawn    <= 1'b0;
      r_jump_req <= 1'b0;
      r_speed    <= SPD_MIN;
      r_score    <= '0;
      r_hi       <= '0;
      r_step_cnt <= '0;
      r_gap      <= GAP_LOAD;
      r_lfsr     <= LFSR_SEED;
      r_anim_cnt <= '0;
      r_anim     <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_spawn    <= 1'b0;
      r_jump_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_div <= '0;
          if (w_jump_edge) begin
            r_state    <= ST_RUN;
            r_run_en   <= 1'b1;
            r_score    <= '0;
            r_speed    <= SPD_MIN;
            r_step_cnt <= '0;
            r_gap      <= GAP_LOAD;
            r_jump_req <= w_jump_edge_nxt;
          end
        end
        ST_RUN: begin
          r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
          // A tick landing on the same clk as collide or stop is dropped
          if (collide) begin
            r_state  <= ST_OVER;
            r_run_en <= 1'b0;
            if (r_score > r_hi) begin
              r_hi <= r_score;
            end
          end else if (w_stop_q) begin
            r_state  <= ST_PAUSE;
            r_run_en <= 1'b0;
          end else begin
            r_jump_req <= w_jump_edge_nxt;
            if (w_div_last) begin
              r_tick <= 1'b1;
              r_lfsr <= w_lfsr_nxt;
              if (r_score < SC_MAX) begin
                r_score <= r_score + SCORE_W'(1);
                if (r_step_cnt == STEP_LAST) begin
                  r_step_cnt <= '0;
                  if (r_speed < SPD_MAX) begin
                    r_speed <= r_speed + SPEED_W'(1);
                  end
                end else begin
                  r_step_cnt <= r_step_cnt + STEP_W'(1);
                end
              end
              if (r_gap == GAP_W'(1)) begin
                r_spawn <= 1'b1;
                r_gap   <= GAP_LOAD + GAP_W'(w_lfsr_nxt[4:0]);
              end else begin
                r_gap <= r_gap - GAP_W'(1);
              end
              if (r_anim_cnt == ANIM_LAST) begin
                r_anim_cnt <= '0;
                r_anim     <= ~r_anim;
              end else begin
                r_anim_cnt <= r_anim_cnt + ANIM_W'(1);
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!w_stop_q) begin
            r_state    <= ST_RUN;
            r_run_en   <= 1'b1;
            r_jump_req <= w_jump_edge_nxt;
          end
        end
        ST_OVER: begin
          r_div <= '0;
          if (w_jump_edge) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_run_en <= 1'b0;
          r_div    <= '0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign run_en     = r_run_en;
  assign game_tick  = r_tick;
  assign jump_req   = r_jump_req;
  assign spawn      = r_spawn;
  assign speed      = r_speed;
  assign score      = r_score;
  assign hi_score   = r_hi;
  assign anim_phase = r_anim;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a cycle model built from the game
// rules is compared every clk, plus hand-computed literal expectations.
module tb_game_sequencer;

  localparam int TD = 4, GM = 3, SS = 5, SMIN = 2, SMAX = 8, AD = 4, SCMAX = 9999;
  localparam int SMAX2 = 3, SCMAX2 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jump_btn = 1'b0;
  logic stop_sw = 1'b0;
  logic collide = 1'b0;

  logic [1:0]  state, state2;
  logic        run_en, run_en2, game_tick, game_tick2, jump_req, jump_req2;
  logic        spawn, spawn2, anim_phase, anim_phase2;
  logic [3:0]  speed, speed2;
  logic [13:0] score, score2, hi_score, hi_score2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_sequencer #(.TICK_DIV(TD), .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .SPEED_STEP(SS),
                   .GAP_MIN(GM), .ANIM_DIV(AD), .SCORE_MAX(SCMAX)) dut (
    .clk(clk), .rst(rst), .jump_btn(jump_btn), .stop_sw(stop_sw), .collide(collide),
    .state(state), .run_en(run_en), .game_tick(game_tick), .jump_req(jump_req),
    .spawn(spawn), .speed(speed), .score(score), .hi_score(hi_score), .anim_phase(anim_phase));

  // Second instance: low speed ceiling and low score ceiling
  game_sequencer #(.TICK_DIV(TD), .SPEED_MIN(SMIN), .SPEED_MAX(SMAX2), .SPEED_STEP(SS),
                   .GAP_MIN(GM), .ANIM_DIV(AD), .SCORE_MAX(SCMAX2)) dut2 (
    .clk(clk), .rst(rst), .jump_btn(jump_btn), .stop_sw(stop_sw), .collide(collide),
    .state(state2), .run_en(run_en2), .game_tick(game_tick2), .jump_req(jump_req2),
    .spawn(spawn2), .speed(speed2), .score(score2), .hi_score(hi_score2), .anim_phase(anim_phase2));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  // Reference model: state is what each output must hold during the next clk
  int m_state, m_div, m_gap, m_anim_cnt;
  int m_score, m_hi, m_speed, m_score2, m_hi2, m_speed2;
  logic m_anim, m_tick, m_spawn, m_jreq;
  logic [7:0] m_lfsr;
  logic [3:0] jh;
  logic [1:0] sh;

  always @(posedge clk or negedge rst) begin : model
    int ns;
    logic ed, sq, tk;
    if (!rst) begin
      m_state = 0; m_div = 0; m_gap = GM; m_anim_cnt = 0; m_anim = 1'b0;
      m_score = 0; m_hi = 0; m_speed = SMIN; m_score2 = 0; m_hi2 = 0; m_speed2 = SMIN;
      m_tick = 1'b0; m_spawn = 1'b0; m_jreq = 1'b0; m_lfsr = 8'hA5; jh = 4'd0; sh = 2'd0;
    end else begin
      ed = jh[2] & ~jh[3];
      sq = sh[1];
      m_tick = 1'b0; m_spawn = 1'b0;
      ns = m_state;
      case (m_state)
        0: begin
          m_div = 0;
          if (ed) begin
            ns = 1; m_score = 0; m_score2 = 0; m_speed = SMIN; m_speed2 = SMIN; m_gap = GM;
          end
        end
        1: begin
          tk = (m_div == TD - 1);
          m_div = (m_div + 1) % TD;
          if (collide) begin
            ns = 3;
            if (m_score > m_hi) m_hi = m_score;
            if (m_score2 > m_hi2) m_hi2 = m_score2;
          end else if (sq) begin
            ns = 2;
          end else if (tk) begin
            m_tick = 1'b1;
            if (m_score < SCMAX) begin
              m_score++;
              if (m_score % SS == 0 && m_speed < SMAX) m_speed++;
            end
            if (m_score2 < SCMAX2) begin
              m_score2++;
              if (m_score2 % SS == 0 && m_speed2 < SMAX2) m_speed2++;
            end
            m_lfsr = ref_lfsr(m_lfsr);
            if (m_gap == 1) begin
              m_spawn = 1'b1;
              m_gap = GM + int'(m_lfsr[4:0]);
            end else begin
              m_gap--;
            end
            m_anim_cnt++;
            if (m_anim_cnt == AD) begin m_anim_cnt = 0; m_anim = ~m_anim; end
          end
        end
        2: if (!sq) ns = 1;
        default: begin m_div = 0; if (ed) ns = 0; end
      endcase
      jh = {jh[2:0], jump_btn};
      sh = {sh[0], stop_sw};
      m_state = ns;
      m_jreq = (jh[2] & ~jh[3]) && (ns == 1);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      check("state", state, m_state);
      check("run_en", run_en, int'(m_state == 1));
      check("game_tick", game_tick, m_tick);
      check("jump_req", jump_req, m_jreq);
      check("spawn", spawn, m_spawn);
      check("speed", speed, m_speed);
      check("score", score, m_score);
      check("hi_score", hi_score, m_hi);
      check("anim_phase", anim_phase, m_anim);
      check("state2", state2, m_state);
      check("speed2", speed2, m_speed2);
      check("score2", score2, m_score2);
      check("hi_score2", hi_score2, m_hi2);
      if (spawn) check("spawn_in_run", state, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_score(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (game_tick && score == 14'(target)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_score timeout actual=%0d expected=%0d", score, target);
    end
  endtask

  task automatic press();
    @(negedge clk);
    jump_btn = 1'b1;
    cyc(6);
    jump_btn = 1'b0;
    cyc(6);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_score", score, 0);
    check("rst_hi", hi_score, 0);
    check("rst_speed", speed, 2);
    check("rst_anim", anim_phase, 0);
    check("rst_spawn", spawn, 0);
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // First press: RUN appears on the 4th clk after the raw edge
    jump_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("start_lat3", state, 0);
    @(posedge clk);
    #1 check("start_lat4", state, 1);
    cyc(4);
    jump_btn = 1'b0;

    wait_score(1);
    check("model_lfsr_step1", m_lfsr, 8'h4A);
    wait_score(2);
    check("no_spawn_t2", spawn, 0);
    wait_score(3);
    check("spawn_t3", spawn, 1);
    wait_score(4);
    check("anim_t4", anim_phase, 1);
    wait_score(5);
    check("speed_s5", speed, 3);

    // Collide on the clk that would carry tick 8
    wait_score(7);
    cyc(3);
    collide = 1'b1;
    cyc(1);
    collide = 1'b0;
    cyc(2);
    check("over_state", state, 3);
    check("over_score", score, 7);
    check("over_hi", hi_score, 7);

    press();
    check("over_to_idle", state, 0);
    press();
    check("idle_to_run", state, 1);

    wait_score(4);
    cyc(1);
    collide = 1'b1;
    cyc(1);
    collide = 1'b0;
    cyc(2);
    check("run2_over", state, 3);
    check("run2_hi_kept", hi_score, 7);

    press();
    press();
    wait_score(10);
    check("speed_s10", speed, 4);
    check("speed2_cap", speed2, 3);

    // Pause with collide and jump ignored
    stop_sw = 1'b1;
    cyc(20);
    check("pause_state", state, 2);
    collide = 1'b1;
    cyc(2);
    collide = 1'b0;
    cyc(40);
    press();
    cyc(40);
    check("pause_score", score, 10);
    check("pause_state2", state, 2);
    stop_sw = 1'b0;
    cyc(5);
    check("resume_state", state, 1);

    // Jump during RUN: jump_req on the 3rd clk after the raw edge
    jump_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("jump_req_on", jump_req, 1);
    @(posedge clk);
    #1 check("jump_req_off", jump_req, 0);
    cyc(3);
    jump_btn = 1'b0;

    wait_score(18);
    check("speed_s18", speed, 5);
    check("score2_sat", score2, 12);

    // Asynchronous reset mid-run
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_score", score, 0);
    check("arst_hi", hi_score, 0);
    check("arst_speed", speed, 2);
    check("arst_run_en", run_en, 0);
    check("arst_anim", anim_phase, 0);
    cyc(2);
    rst = 1'b1;
    cyc(5);
    check("post_rst_idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
